cosine_sim_stream: RTL and testbench

//  Streaming, parametrised cosine-similarity engine. Vector pairs (A,B) arrive one element per beat over a

---
 rtl/cosine_sim_stream.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_cosine_sim_stream.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/cosine_sim_stream.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : cosine_sim_stream
// Purpose  : Streaming cosine-similarity engine. Element pairs (a,b) arrive
//            one per beat on a valid/ready stream. The block accumulates
//            dot(A,B), |A|^2 and |B|^2, takes R = floor(sqrt(|A|^2*|B|^2))
//            with a bit-serial restoring square root, and then forms
//            dot/R as a signed Q1.FRAC word with a restoring divider.
// Ports    : clk, rst_n            clock / async active-low reset
//            in_valid/in_ready     input handshake (ready only in ACC)
//            in_a, in_b            signed DW-bit elements
//            in_last               final element of the current pair
//            out_valid/out_ready   result handshake (valid held until ready)
//            out_sim               signed Q1.FRAC similarity
//            out_zero              a norm was zero, out_sim forced to 0
//            out_len               elements accepted (saturates at MAX_LEN)
//            out_len_err           more than MAX_LEN elements were received
//            busy                  engine is not accepting elements
// Revision : 1.0  initial release
// ============================================================================
module cosine_sim_stream #(
  parameter  int DW      = 16,
  parameter  int MAX_LEN = 64,
  parameter  int FRAC    = 15,
  localparam int LW      = $clog2(MAX_LEN + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DW-1:0]        in_a,
  input  logic [DW-1:0]        in_b,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [FRAC+1:0]      out_sim,
  output logic                 out_zero,
  output logic [LW-1:0]        out_len,
  output logic                 out_len_err,
  output logic                 busy
);

  // Accumulator width: a product of two DW-bit values plus growth for
  // MAX_LEN additions never overflows.
  localparam int AW = 2*DW + $clog2(MAX_LEN);
  // Quotient width: |dot| shifted left by FRAC.
  localparam int QW = AW + FRAC;
  localparam int CW = $clog2(QW + 1);

  localparam logic [QW-1:0]   Q_ONE   = {{(QW-1){1'b0}}, 1'b1} << FRAC;
  localparam logic [FRAC+1:0] SIM_ONE = {{(FRAC+1){1'b0}}, 1'b1} << FRAC;

  typedef enum logic [2:0] {
    S_ACC  = 3'd0,
    S_CHK  = 3'd1,
    S_SQRT = 3'd2,
    S_DIV  = 3'd3,
    S_OUT  = 3'd4
  } state_t;

  state_t state, state_nx;

  // --------------------------------------------------------------------------
  // Element products
  // --------------------------------------------------------------------------
  logic                   beat;
  logic signed [2*DW-1:0] a_ext, b_ext;
  logic signed [2*DW-1:0] prod_ab, prod_aa, prod_bb;
  logic        [AW-1:0]   term_ab, term_aa, term_bb;

  assign beat    = in_valid & in_ready;
  assign a_ext   = {{DW{in_a[DW-1]}}, in_a};
  assign b_ext   = {{DW{in_b[DW-1]}}, in_b};
  // The exact products fit in 2*DW bits, so the truncated multiply is exact.
  assign prod_ab = a_ext * b_ext;
  assign prod_aa = a_ext * a_ext;
  assign prod_bb = b_ext * b_ext;
  assign term_ab = {{(AW-2*DW){prod_ab[2*DW-1]}}, prod_ab};
  // Squares are never negative, so they are zero-extended.
  assign term_aa = {{(AW-2*DW){1'b0}}, prod_aa};
  assign term_bb = {{(AW-2*DW){1'b0}}, prod_bb};

  // --------------------------------------------------------------------------
  // Accumulators and bookkeeping
  // --------------------------------------------------------------------------
  logic signed [AW-1:0] dot;
  logic        [AW-1:0] na, nb;
  logic        [LW-1:0] len;
  logic                 len_err;
  logic                 at_max;
  logic                 norm_zero;
  logic      [2*AW-1:0] p_w;
  logic        [AW-1:0] dot_abs;

  assign at_max    = (len == LW'(MAX_LEN));
  assign norm_zero = (na == '0) || (nb == '0);
  assign p_w       = {{AW{1'b0}}, na} * {{AW{1'b0}}, nb};
  assign dot_abs   = dot[AW-1] ? -dot : dot;

  // --------------------------------------------------------------------------
  // Restoring square root: two radicand bits enter per cycle, one root bit
  // leaves. The partial remainder never exceeds 2*root, so AW bits hold it
  // for every step whose result is reused.
  // --------------------------------------------------------------------------
  logic [2*AW-1:0] rad;
  logic [AW-1:0]   sq_rem, sq_root;
  logic [AW+1:0]   sq_sh, sq_trial;
  logic            sq_ge;
  logic [AW-1:0]   sq_rem_nx, sq_root_nx;

  assign sq_sh      = {sq_rem, rad[2*AW-1 -: 2]};
  assign sq_trial   = {sq_root, 2'b01};
  assign sq_ge      = (sq_sh >= sq_trial);
  assign sq_rem_nx  = sq_ge ? (sq_sh[AW-1:0] - sq_trial[AW-1:0]) : sq_sh[AW-1:0];
  assign sq_root_nx = {sq_root[AW-2:0], sq_ge};

  // --------------------------------------------------------------------------
  // Restoring divider: dividend bits shift out of the top of dv while the
  // quotient bits shift in at the bottom, so dv ends holding the quotient.
  // --------------------------------------------------------------------------
  logic [QW-1:0]   dv;
  logic [AW-1:0]   dv_rem;
  logic [AW:0]     dv_sh;
  logic            dv_ge;
  logic [AW-1:0]   dv_rem_nx;
  logic [QW-1:0]   q_nx;
  logic [FRAC+1:0] q_sat;
  logic [FRAC+1:0] sim_nx;

  assign dv_sh     = {dv_rem, dv[QW-1]};
  assign dv_ge     = (dv_sh >= {1'b0, sq_root});
  assign dv_rem_nx = dv_ge ? (dv_sh[AW-1:0] - sq_root) : dv_sh[AW-1:0];
  assign q_nx      = {dv[QW-2:0], dv_ge};
  assign q_sat     = (q_nx > Q_ONE) ? SIM_ONE : q_nx[FRAC+1:0];
  // Magnitude is computed first, so negating gives truncation toward zero.
  assign sim_nx    = dot[AW-1] ? -q_sat : q_sat;

  // --------------------------------------------------------------------------
  // Step counter shared by SQRT and DIV
  // --------------------------------------------------------------------------
  logic [CW-1:0] cnt;
  logic          last_sq, last_dv;

  assign last_sq = (cnt == CW'(AW - 1));
  assign last_dv = (cnt == CW'(QW - 1));

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_ACC;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      S_ACC: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (beat && in_last) begin
          state_nx = S_CHK;
        end
      end
      S_CHK: begin
        state_nx = norm_zero ? S_OUT : S_SQRT;
      end
      S_SQRT: begin
        if (last_sq) begin
          state_nx = S_DIV;
        end
      end
      S_DIV: begin
        if (last_dv) begin
          state_nx = S_OUT;
        end
      end
      S_OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nx = S_ACC;
        end
      end
      default: begin
        state_nx = S_ACC;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dot         <= '0;
      na          <= '0;
      nb          <= '0;
      len         <= '0;
      len_err     <= 1'b0;
      rad         <= '0;
      sq_rem      <= '0;
      sq_root     <= '0;
      dv          <= '0;
      dv_rem      <= '0;
      cnt         <= '0;
      out_sim     <= '0;
      out_zero    <= 1'b0;
      out_len     <= '0;
      out_len_err <= 1'b0;
    end else begin
      case (state)
        S_ACC: begin
          if (beat) begin
            if (at_max) begin
              // Overlong vector: the beat is consumed but not accumulated.
              len_err <= 1'b1;
            end else begin
              dot <= dot + term_ab;
              na  <= na + term_aa;
              nb  <= nb + term_bb;
              len <= len + 1'b1;
            end
          end
        end
        S_CHK: begin
          out_len     <= len;
          out_len_err <= len_err;
          cnt         <= '0;
          sq_rem      <= '0;
          sq_root     <= '0;
          rad         <= p_w;
          if (norm_zero) begin
            out_sim  <= '0;
            out_zero <= 1'b1;
          end else begin
            out_zero <= 1'b0;
          end
        end
        S_SQRT: begin
          sq_rem  <= sq_rem_nx;
          sq_root <= sq_root_nx;
          rad     <= {rad[2*AW-3:0], 2'b00};
          if (last_sq) begin
            cnt    <= '0;
            dv     <= {dot_abs, {FRAC{1'b0}}};
            dv_rem <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DIV: begin
          dv_rem <= dv_rem_nx;
          dv     <= q_nx;
          cnt    <= cnt + 1'b1;
          if (last_dv) begin
            out_sim <= sim_nx;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            dot     <= '0;
            na      <= '0;
            nb      <= '0;
            len     <= '0;
            len_err <= 1'b0;
          end
        end
        default: begin
          cnt <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cosine_sim_stream.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_cosine_sim_stream
// Purpose  : Self-checking bench for cosine_sim_stream at default parameters.
//            A table of vector pairs with hand-computed similarity, length,
//            flags and latency is streamed through the engine, followed by
//            hand-written sequences for output backpressure, overlong
//            vectors and asynchronous reset in the middle of a computation.
// Revision : 1.0  initial release
// ============================================================================
module tb_cosine_sim_stream;

  localparam int DW      = 16;
  localparam int MAX_LEN = 64;
  localparam int FRAC    = 15;
  localparam int LW      = $clog2(MAX_LEN + 1);
  localparam int NV      = 15;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [DW-1:0]   in_a = '0;
  logic [DW-1:0]   in_b = '0;
  logic            in_last = 1'b0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [FRAC+1:0] out_sim;
  logic            out_zero;
  logic [LW-1:0]   out_len;
  logic            out_len_err;
  logic            busy;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  cosine_sim_stream #(.DW(DW), .MAX_LEN(MAX_LEN), .FRAC(FRAC)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sim(out_sim), .out_zero(out_zero),
    .out_len(out_len), .out_len_err(out_len_err),
    .busy(busy)
  );

  typedef logic [7:0][15:0] elems_t;

  typedef struct packed {
    int     n;
    elems_t a;
    elems_t b;
    int     sim;
    logic   zero;
    int     len;
    logic   err;
    int     lat;
  } vec_t;

  vec_t tbl [NV];

  function automatic elems_t pk(input int e0, input int e1, input int e2, input int e3,
                                input int e4, input int e5, input int e6, input int e7);
    elems_t r;
    r[0] = e0[15:0]; r[1] = e1[15:0]; r[2] = e2[15:0]; r[3] = e3[15:0];
    r[4] = e4[15:0]; r[5] = e5[15:0]; r[6] = e6[15:0]; r[7] = e7[15:0];
    return r;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) begin
      passed++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Called aligned 1 ns after a rising edge; leaves the same alignment.
  task automatic send(input vec_t v);
    for (int i = 0; i < v.n; i++) begin
      in_valid = 1'b1;
      in_a     = v.a[i];
      in_b     = v.b[i];
      in_last  = (i == v.n - 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Counts cycles after the last beat until out_valid is seen (bounded).
  task automatic wait_out(input string name, output int lat);
    lat = 0;
    while (lat < 300) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
    end
    if (!out_valid) chk({name, " timeout"}, 0, 1);
  endtask

  // Accept the result; returns aligned 1 ns after the accepting edge.
  task automatic ack(input string name, input int exp_sim);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({name, " valid_drop"}, out_valid, 0);
    chk({name, " sim_hold"}, $signed(out_sim), exp_sim);
    chk({name, " ready_back"}, in_ready, 1);
  endtask

  task automatic run_vec(input string name, input vec_t v);
    int lat;
    send(v);
    wait_out(name, lat);
    chk({name, " latency"}, lat, v.lat);
    chk({name, " sim"}, $signed(out_sim), v.sim);
    chk({name, " zero"}, out_zero, v.zero);
    chk({name, " len"}, out_len, v.len);
    chk({name, " len_err"}, out_len_err, v.err);
    ack(name, v.sim);
  endtask

  initial begin
    int lat;
    vec_t v;

    tbl[0]  = '{n:5, a:pk(1,1,1,1,1,0,0,0),  b:pk(1,1,1,1,1,0,0,0),      sim:32768,  zero:1'b0, len:5, err:1'b0, lat:93};
    tbl[1]  = '{n:5, a:pk(1,2,3,4,5,0,0,0),  b:pk(-1,-2,-3,-4,-5,0,0,0), sim:-32768, zero:1'b0, len:5, err:1'b0, lat:93};
    tbl[2]  = '{n:4, a:pk(1,0,1,0,0,0,0,0),  b:pk(0,1,0,1,0,0,0,0),      sim:0,      zero:1'b0, len:4, err:1'b0, lat:93};
    tbl[3]  = '{n:2, a:pk(3,4,0,0,0,0,0,0),  b:pk(4,3,0,0,0,0,0,0),      sim:31457,  zero:1'b0, len:2, err:1'b0, lat:93};
    tbl[4]  = '{n:2, a:pk(-3,-4,0,0,0,0,0,0),b:pk(4,3,0,0,0,0,0,0),      sim:-31457, zero:1'b0, len:2, err:1'b0, lat:93};
    tbl[5]  = '{n:3, a:pk(0,0,0,0,0,0,0,0),  b:pk(5,6,7,0,0,0,0,0),      sim:0,      zero:1'b1, len:3, err:1'b0, lat:2};
    tbl[6]  = '{n:1, a:pk(5,0,0,0,0,0,0,0),  b:pk(-3,0,0,0,0,0,0,0),     sim:-32768, zero:1'b0, len:1, err:1'b0, lat:93};
    tbl[7]  = '{n:2, a:pk(2,1,0,0,0,0,0,0),  b:pk(1,3,0,0,0,0,0,0),      sim:23405,  zero:1'b0, len:2, err:1'b0, lat:93};
    tbl[8]  = '{n:2, a:pk(7,0,0,0,0,0,0,0),  b:pk(1,1,0,0,0,0,0,0),      sim:25486,  zero:1'b0, len:2, err:1'b0, lat:93};
    tbl[9]  = '{n:2, a:pk(7,0,0,0,0,0,0,0),  b:pk(-1,-1,0,0,0,0,0,0),    sim:-25486, zero:1'b0, len:2, err:1'b0, lat:93};
    tbl[10] = '{n:2, a:pk(1,1,0,0,0,0,0,0),  b:pk(1,0,0,0,0,0,0,0),      sim:32768,  zero:1'b0, len:2, err:1'b0, lat:93};
    tbl[11] = '{n:1, a:pk(-32768,0,0,0,0,0,0,0), b:pk(-32768,0,0,0,0,0,0,0), sim:32768, zero:1'b0, len:1, err:1'b0, lat:93};
    tbl[12] = '{n:1, a:pk(1,0,0,0,0,0,0,0),  b:pk(0,0,0,0,0,0,0,0),      sim:0,      zero:1'b1, len:1, err:1'b0, lat:2};
    tbl[13] = '{n:2, a:pk(2,3,0,0,0,0,0,0),  b:pk(4,1,0,0,0,0,0,0),      sim:25746,  zero:1'b0, len:2, err:1'b0, lat:93};
    tbl[14] = '{n:1, a:pk(32767,0,0,0,0,0,0,0), b:pk(-32768,0,0,0,0,0,0,0), sim:-32768, zero:1'b0, len:1, err:1'b0, lat:93};

    // Reset state
    #12;
    chk("rst in_ready", in_ready, 1);
    chk("rst out_valid", out_valid, 0);
    chk("rst out_sim", out_sim, 0);
    chk("rst out_zero", out_zero, 0);
    chk("rst out_len", out_len, 0);
    chk("rst out_len_err", out_len_err, 0);
    chk("rst busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int k = 0; k < NV; k++) begin
      run_vec($sformatf("vec%0d", k), tbl[k]);
    end

    // Backpressure: result held, inputs refused, stray beats not absorbed.
    send(tbl[7]);
    wait_out("bp", lat);
    chk("bp latency", lat, 93);
    in_valid = 1'b1;
    in_a     = 16'd9;
    in_b     = 16'd9;
    in_last  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("bp valid c%0d", i), out_valid, 1);
      chk($sformatf("bp ready c%0d", i), in_ready, 0);
      chk($sformatf("bp sim c%0d", i), $signed(out_sim), 23405);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    ack("bp", 23405);
    run_vec("bp_next", tbl[3]);

    // Overlong vector: 65 beats of ones, the last is counted as an error.
    for (int i = 0; i < 65; i++) begin
      in_valid = 1'b1;
      in_a     = 16'd1;
      in_b     = 16'd1;
      in_last  = (i == 64);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    wait_out("long", lat);
    chk("long latency", lat, 93);
    chk("long sim", $signed(out_sim), 32768);
    chk("long len", out_len, 64);
    chk("long len_err", out_len_err, 1);
    chk("long zero", out_zero, 0);
    ack("long", 32768);

    // Next pair after an overlong one starts with clean error state.
    run_vec("after_long", tbl[8]);

    // Asynchronous reset in the middle of SQRT.
    send(tbl[3]);
    repeat (10) @(negedge clk);
    chk("midsqrt busy", busy, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst out_valid", out_valid, 0);
    chk("midrst in_ready", in_ready, 1);
    chk("midrst busy", busy, 0);
    chk("midrst out_len", out_len, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_vec("post_rst", tbl[9]);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
